// File: rtl/operand_collector_pkg.sv
// Shared types and default sizes for the operand collector.
//   Def*        default parameter values used by the interface and the top
//   inst_t      decoded instruction as produced by the decoder/dispatcher
//   reg_data_t  one register's worth of operand data, all lanes
package operand_collector_pkg;

  localparam int unsigned DefPcWidth         = 32;
  localparam int unsigned DefWarpWidth       = 32;
  localparam int unsigned DefRegIdxWidth     = 6;
  localparam int unsigned DefRegWidth        = 32;
  localparam int unsigned DefOperandsPerInst = 2;
  localparam int unsigned DefNumTags         = 8;

  typedef struct packed {
    logic [7:0] opcode;
    logic [3:0] eu_sel;
  } inst_t;

  typedef logic [DefWarpWidth-1:0][DefRegWidth-1:0] reg_data_t;

endpackage

// File: rtl/operand_collector_if.sv
// Bundle of the three channels around the operand collector:
//   disp_*  dispatcher -> collector instruction handoff (valid/ready)
//   rf_*    single-outstanding register-file read port (req valid/ready, rsp valid)
//   opc_*   collector -> execution unit issue (valid/ready) plus the tag-release pulse
// Modports: master = surrounding pipeline (dispatcher, RF, EU), slave = collector.
interface operand_collector_if
  import operand_collector_pkg::*;
#(
  parameter int unsigned PcWidth         = DefPcWidth,
  parameter int unsigned WarpWidth       = DefWarpWidth,
  parameter int unsigned RegIdxWidth     = DefRegIdxWidth,
  parameter int unsigned RegWidth        = DefRegWidth,
  parameter int unsigned OperandsPerInst = DefOperandsPerInst,
  parameter int unsigned NumTags         = DefNumTags
) ();
  localparam int unsigned TagWidth = $clog2(NumTags);

  // dispatcher side
  logic                                         disp_valid;
  logic                                         opc_ready;
  logic [TagWidth-1:0]                          disp_tag;
  logic [PcWidth-1:0]                           disp_pc;
  logic [WarpWidth-1:0]                         disp_act_mask;
  inst_t                                        disp_inst;
  logic [RegIdxWidth-1:0]                       disp_dst;
  logic [OperandsPerInst-1:0]                   disp_operands_is_reg;
  logic [OperandsPerInst-1:0][RegIdxWidth-1:0]  disp_operands;

  // register file side
  logic                                         rf_req_valid;
  logic                                         rf_req_ready;
  logic [RegIdxWidth-1:0]                       rf_req_reg;
  logic                                         rf_rsp_valid;
  logic [WarpWidth-1:0][RegWidth-1:0]           rf_rsp_data;

  // execution unit side
  logic                                         eu_ready;
  logic                                         opc_valid;
  logic [TagWidth-1:0]                          opc_tag;
  logic [PcWidth-1:0]                           opc_pc;
  logic [WarpWidth-1:0]                         opc_act_mask;
  inst_t                                        opc_inst;
  logic [RegIdxWidth-1:0]                       opc_dst;
  logic [OperandsPerInst-1:0][WarpWidth-1:0][RegWidth-1:0] opc_operand_data;
  logic                                         opc_eu_handshake;
  logic [TagWidth-1:0]                          opc_eu_tag;

  modport master (
    output disp_valid, disp_tag, disp_pc, disp_act_mask, disp_inst, disp_dst,
           disp_operands_is_reg, disp_operands,
    output rf_req_ready, rf_rsp_valid, rf_rsp_data,
    output eu_ready,
    input  opc_ready, rf_req_valid, rf_req_reg,
    input  opc_valid, opc_tag, opc_pc, opc_act_mask, opc_inst, opc_dst,
           opc_operand_data, opc_eu_handshake, opc_eu_tag
  );

  modport slave (
    input  disp_valid, disp_tag, disp_pc, disp_act_mask, disp_inst, disp_dst,
           disp_operands_is_reg, disp_operands,
    input  rf_req_ready, rf_rsp_valid, rf_rsp_data,
    input  eu_ready,
    output opc_ready, rf_req_valid, rf_req_reg,
    output opc_valid, opc_tag, opc_pc, opc_act_mask, opc_inst, opc_dst,
           opc_operand_data, opc_eu_handshake, opc_eu_tag
  );

endinterface

// File: rtl/operand_collector.sv
// Operand collector: accepts one dispatched instruction, reads its register
// operands one at a time from the register file, fills immediate operands
// directly, then presents the instruction plus operand data to the execution
// unit. The tag is echoed on the EU handshake so the dispatcher can free it.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous reset, active low
//   bus     operand_collector_if.slave (dispatcher, RF read port, EU issue)
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int unsigned PcWidth         = DefPcWidth,
  parameter int unsigned WarpWidth       = DefWarpWidth,
  parameter int unsigned RegIdxWidth     = DefRegIdxWidth,
  parameter int unsigned RegWidth        = DefRegWidth,
  parameter int unsigned OperandsPerInst = DefOperandsPerInst,
  parameter int unsigned NumTags         = DefNumTags
) (
  input logic               clk_i,
  input logic               rst_ni,
  operand_collector_if.slave bus
);

  localparam int unsigned TagWidth = $clog2(NumTags);
  localparam int unsigned SelW     = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] RSP   = 2'd2;
  localparam logic [1:0] ISSUE = 2'd3;

  logic [1:0] state_q, state_d;

  // held instruction fields
  logic [TagWidth-1:0]                         tag_q;
  logic [PcWidth-1:0]                          pc_q;
  logic [WarpWidth-1:0]                        mask_q;
  inst_t                                       inst_q;
  logic [RegIdxWidth-1:0]                      dst_q;
  logic [OperandsPerInst-1:0][RegIdxWidth-1:0] idx_q;

  // operand buffer and outstanding register reads
  logic [OperandsPerInst-1:0]                               pending_q;
  logic [OperandsPerInst-1:0][WarpWidth-1:0][RegWidth-1:0]  opnd_q;

  logic                       accept;
  logic [SelW-1:0]            sel;
  logic [OperandsPerInst-1:0] rsp_wr;

  // Reset gates ready so the dispatcher never sees an accept while held in reset.
  assign bus.opc_ready = rst_ni && (state_q == IDLE);
  assign accept        = bus.disp_valid && bus.opc_ready;

  // Lowest-numbered pending operand. pending_q does not change between REQ
  // and the matching RSP, so the same select steers the response write.
  always_comb begin
    sel = '0;
    for (int i = OperandsPerInst - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = SelW'(i);
    end
  end

  always_comb begin
    rsp_wr = '0;
    if (state_q == RSP && bus.rf_rsp_valid) rsp_wr[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (|bus.disp_operands_is_reg) ? REQ : ISSUE;
      REQ:     if (bus.rf_req_ready) state_d = RSP;
      RSP:     if (bus.rf_rsp_valid) state_d = ((pending_q & ~rsp_wr) != '0) ? REQ : ISSUE;
      ISSUE:   if (bus.eu_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q  <= '0;
      pc_q   <= '0;
      mask_q <= '0;
      inst_q <= '0;
      dst_q  <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      tag_q  <= bus.disp_tag;
      pc_q   <= bus.disp_pc;
      mask_q <= bus.disp_act_mask;
      inst_q <= bus.disp_inst;
      dst_q  <= bus.disp_dst;
      idx_q  <= bus.disp_operands;
    end
  end

  // Immediates are broadcast to every lane at accept time; register slots are
  // filled one response at a time. accept and rsp_wr never coincide (IDLE vs RSP).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      opnd_q    <= '0;
    end else begin
      if (accept) begin
        pending_q <= bus.disp_operands_is_reg;
        for (int i = 0; i < OperandsPerInst; i++) begin
          if (!bus.disp_operands_is_reg[i]) begin
            for (int l = 0; l < WarpWidth; l++) begin
              opnd_q[i][l] <= RegWidth'(bus.disp_operands[i]);
            end
          end
        end
      end
      for (int i = 0; i < OperandsPerInst; i++) begin
        if (rsp_wr[i]) begin
          opnd_q[i]    <= bus.rf_rsp_data;
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rf_req_valid = (state_q == REQ);
  assign bus.rf_req_reg   = bus.rf_req_valid ? idx_q[sel] : '0;

  assign bus.opc_valid        = (state_q == ISSUE);
  assign bus.opc_tag          = tag_q;
  assign bus.opc_pc           = pc_q;
  assign bus.opc_act_mask     = mask_q;
  assign bus.opc_inst         = inst_q;
  assign bus.opc_dst          = dst_q;
  assign bus.opc_operand_data = opnd_q;
  assign bus.opc_eu_handshake = bus.opc_valid && bus.eu_ready;
  assign bus.opc_eu_tag       = bus.opc_eu_handshake ? tag_q : '0;

  // ---------------------------------------------------------------- checks
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.rf_req_valid && !bus.rf_req_ready |=> bus.rf_req_valid && $stable(bus.rf_req_reg));

  a_issue_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.opc_valid && !bus.eu_ready |=> bus.opc_valid && $stable(tag_q) && $stable(pc_q)
      && $stable(mask_q) && $stable(inst_q) && $stable(dst_q) && $stable(opnd_q));

  a_onehot_wr: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rsp_wr));

  a_rsp_in_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.rf_rsp_valid |-> state_q == RSP);

endmodule

// File: tb/tb_operand_collector.sv
module tb_operand_collector;
  import operand_collector_pkg::*;

  localparam int unsigned TagW = $clog2(DefNumTags);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_collector_if bus ();
  operand_collector dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int   n_vec = 0;
  int   n_bad = 0;
  int   rf_delay = 0;
  int   rf_lat   = 1;
  logic inject_stale = 1'b0;
  int   req_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rf_lane(input int r, input int l);
    return 32'hA500_0000 | (32'(r) << 16) | 32'(l);
  endfunction

  function automatic reg_data_t rf_data(input int r);
    reg_data_t d;
    for (int l = 0; l < DefWarpWidth; l++) d[l] = rf_lane(r, l);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register-file model: ready after rf_delay waiting cycles, data rf_lat cycles later.
  initial begin : rf_model
    int   wait_cnt = 0;
    int   rsp_cnt  = 0;
    int   rsp_reg  = 0;
    logic rsp_pend = 1'b0;
    bus.rf_req_ready = 1'b0;
    bus.rf_rsp_valid = 1'b0;
    bus.rf_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.rf_req_ready = 1'b0;
      bus.rf_rsp_valid = 1'b0;
      if (!rst_n) begin
        rsp_pend = 1'b0;
        wait_cnt = 0;
        if (inject_stale) begin
          bus.rf_rsp_valid = 1'b1;
          bus.rf_rsp_data  = '1;
        end
      end else if (rsp_pend) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.rf_rsp_valid = 1'b1;
          bus.rf_rsp_data  = rf_data(rsp_reg);
          rsp_pend = 1'b0;
        end
      end else if (bus.rf_req_valid) begin
        if (wait_cnt < rf_delay) begin
          wait_cnt++;
        end else begin
          bus.rf_req_ready = 1'b1;
          wait_cnt = 0;
          rsp_reg  = int'(bus.rf_req_reg);
          rsp_pend = 1'b1;
          rsp_cnt  = rf_lat;
          req_log.push_back(rsp_reg);
        end
      end
    end
  end

  task automatic dispatch(input logic [TagW-1:0] tag, input logic [31:0] pc,
                          input logic [31:0] mask, input inst_t inst, input logic [5:0] dst,
                          input logic [1:0] is_reg, input logic [5:0] op0, input logic [5:0] op1);
    bus.disp_valid           = 1'b1;
    bus.disp_tag             = tag;
    bus.disp_pc              = pc;
    bus.disp_act_mask        = mask;
    bus.disp_inst            = inst;
    bus.disp_dst             = dst;
    bus.disp_operands_is_reg = is_reg;
    bus.disp_operands[0]     = op0;
    bus.disp_operands[1]     = op1;
    #1;
    for (int i = 0; i < 30 && !bus.opc_ready; i++) tick();
    chk("disp_ready", 64'(bus.opc_ready), 64'd1);
    tick();
    bus.disp_valid = 1'b0;
  endtask

  // Returns the cycle index (accept edge = 0) at which opc_valid is first seen.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!bus.opc_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic chk_ops(input string tag, input int slot, input bit imm, input int val);
    for (int l = 0; l < DefWarpWidth; l++) begin
      chk($sformatf("%s[%0d]", tag, l), 64'(bus.opc_operand_data[slot][l]),
          imm ? 64'(val) : 64'(rf_lane(val, l)));
    end
  endtask

  task automatic issue_now(input int tag);
    chk("hs_idle", 64'(bus.opc_eu_handshake), 64'd0);
    bus.eu_ready = 1'b1;
    #1;
    chk("hs_pulse", 64'(bus.opc_eu_handshake), 64'd1);
    chk("eu_tag", 64'(bus.opc_eu_tag), 64'(tag));
    tick();
    bus.eu_ready = 1'b0;
    #1;
    chk("hs_after", 64'(bus.opc_eu_handshake), 64'd0);
    chk("valid_after", 64'(bus.opc_valid), 64'd0);
    chk("ready_after", 64'(bus.opc_ready), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin : main
    int lat;
    int base;
    bus.disp_valid           = 1'b0;
    bus.disp_tag             = '0;
    bus.disp_pc              = '0;
    bus.disp_act_mask        = '0;
    bus.disp_inst            = '0;
    bus.disp_dst             = '0;
    bus.disp_operands_is_reg = '0;
    bus.disp_operands        = '0;
    bus.eu_ready             = 1'b0;

    // reset
    tick();
    tick();
    chk("rst_ready", 64'(bus.opc_ready), 64'd0);
    chk("rst_valid", 64'(bus.opc_valid), 64'd0);
    chk("rst_req", 64'(bus.rf_req_valid), 64'd0);
    chk("rst_hs", 64'(bus.opc_eu_handshake), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(bus.opc_ready), 64'd1);
    tick();

    // both operands immediate
    base = req_log.size();
    dispatch(3'd1, 32'h0000_0100, 32'hFFFF_FFFF, '{opcode: 8'h21, eu_sel: 4'h1}, 6'd3, 2'b00, 6'd5, 6'd9);
    wait_valid(1, lat);
    chk("imm_lat", 64'(lat), 64'd1);
    chk("imm_busy", 64'(bus.opc_ready), 64'd0);
    chk("imm_noreq", 64'(bus.rf_req_valid), 64'd0);
    chk("imm_tag", 64'(bus.opc_tag), 64'd1);
    chk("imm_pc", 64'(bus.opc_pc), 64'h100);
    chk("imm_mask", 64'(bus.opc_act_mask), 64'hFFFF_FFFF);
    chk("imm_inst", 64'(bus.opc_inst), 64'h211);
    chk("imm_dst", 64'(bus.opc_dst), 64'd3);
    chk_ops("imm_op0", 0, 1'b1, 5);
    chk_ops("imm_op1", 1, 1'b1, 9);
    chk("imm_nreq", 64'(req_log.size() - base), 64'd0);
    issue_now(1);

    // both operands register, r3 then r7
    rf_delay = 0;
    rf_lat   = 1;
    base = req_log.size();
    dispatch(3'd2, 32'h0000_0200, 32'h0000_FFFF, '{opcode: 8'h30, eu_sel: 4'h2}, 6'd8, 2'b11, 6'd3, 6'd7);
    wait_valid(1, lat);
    chk("reg_lat", 64'(lat), 64'd5);
    chk("reg_nreq", 64'(req_log.size() - base), 64'd2);
    if (req_log.size() - base == 2) begin
      chk("reg_req0", 64'(req_log[base]), 64'd3);
      chk("reg_req1", 64'(req_log[base+1]), 64'd7);
    end
    chk_ops("reg_op0", 0, 1'b0, 3);
    chk_ops("reg_op1", 1, 1'b0, 7);
    issue_now(2);

    // mixed: op0 immediate 2, op1 register r4
    base = req_log.size();
    dispatch(3'd3, 32'h0000_0300, 32'h0000_0001, '{opcode: 8'h31, eu_sel: 4'h3}, 6'd9, 2'b10, 6'd2, 6'd4);
    wait_valid(1, lat);
    chk("mix_lat", 64'(lat), 64'd3);
    chk("mix_nreq", 64'(req_log.size() - base), 64'd1);
    if (req_log.size() - base == 1) chk("mix_req0", 64'(req_log[base]), 64'd4);
    chk_ops("mix_op0", 0, 1'b1, 2);
    chk_ops("mix_op1", 1, 1'b0, 4);
    issue_now(3);

    // EU back-pressure for 4 cycles, tag 6
    dispatch(3'd6, 32'hCAFE_0040, 32'h0000_00F0, '{opcode: 8'h44, eu_sel: 4'h4}, 6'd11, 2'b00, 6'd1, 6'd2);
    wait_valid(1, lat);
    chk("bp_lat", 64'(lat), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 64'(bus.opc_valid), 64'd1);
      chk("bp_ready", 64'(bus.opc_ready), 64'd0);
      chk("bp_hs", 64'(bus.opc_eu_handshake), 64'd0);
      chk("bp_eutag", 64'(bus.opc_eu_tag), 64'd0);
      chk("bp_tag", 64'(bus.opc_tag), 64'd6);
      chk("bp_pc", 64'(bus.opc_pc), 64'hCAFE_0040);
      chk("bp_op1", 64'(bus.opc_operand_data[1][7]), 64'd2);
      tick();
    end
    chk("bp_mask", 64'(bus.opc_act_mask), 64'hF0);
    issue_now(6);

    // slow RF: ready after 3 waiting cycles, data 5 cycles later; duplicate r10
    rf_delay = 3;
    rf_lat   = 5;
    base = req_log.size();
    dispatch(3'd4, 32'h0000_0400, 32'hFFFF_0000, '{opcode: 8'h50, eu_sel: 4'h5}, 6'd12, 2'b11, 6'd10, 6'd10);
    for (int i = 0; i < 3; i++) begin
      chk("slow_reqv", 64'(bus.rf_req_valid), 64'd1);
      chk("slow_reqr", 64'(bus.rf_req_reg), 64'd10);
      chk("slow_busy", 64'(bus.opc_ready), 64'd0);
      tick();
    end
    wait_valid(4, lat);
    chk("slow_lat", 64'(lat), 64'd19);
    chk("slow_nreq", 64'(req_log.size() - base), 64'd2);
    if (req_log.size() - base == 2) begin
      chk("slow_req0", 64'(req_log[base]), 64'd10);
      chk("slow_req1", 64'(req_log[base+1]), 64'd10);
    end
    chk_ops("slow_op0", 0, 1'b0, 10);
    chk_ops("slow_op1", 1, 1'b0, 10);
    issue_now(4);

    // reset while waiting for a response
    rf_delay = 0;
    rf_lat   = 8;
    dispatch(3'd5, 32'h0000_0500, 32'h0000_0F0F, '{opcode: 8'h60, eu_sel: 4'h6}, 6'd13, 2'b01, 6'd12, 6'd7);
    tick();
    chk("mid_rsp_req", 64'(bus.rf_req_valid), 64'd0);
    chk("mid_busy", 64'(bus.opc_ready), 64'd0);
    chk("mid_imm", 64'(bus.opc_operand_data[1][0]), 64'd7);
    rst_n        = 1'b0;
    inject_stale = 1'b1;
    #1;
    chk("mr_ready", 64'(bus.opc_ready), 64'd0);
    chk("mr_req", 64'(bus.rf_req_valid), 64'd0);
    chk("mr_reqr", 64'(bus.rf_req_reg), 64'd0);
    chk("mr_valid", 64'(bus.opc_valid), 64'd0);
    chk("mr_hs", 64'(bus.opc_eu_handshake), 64'd0);
    chk("mr_tag", 64'(bus.opc_tag), 64'd0);
    chk("mr_pc", 64'(bus.opc_pc), 64'd0);
    chk("mr_opnd", 64'(bus.opc_operand_data[1][0]), 64'd0);
    tick();
    inject_stale = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(bus.opc_ready), 64'd1);
    chk("rel_valid", 64'(bus.opc_valid), 64'd0);
    tick();
    chk("stale_ready", 64'(bus.opc_ready), 64'd1);
    chk("stale_req", 64'(bus.rf_req_valid), 64'd0);
    chk("stale_opnd", 64'(bus.opc_operand_data[0][0]), 64'd0);

    // recovery after reset
    rf_lat = 1;
    base = req_log.size();
    dispatch(3'd7, 32'h0000_0700, 32'hFFFF_FFFF, '{opcode: 8'h70, eu_sel: 4'h7}, 6'd14, 2'b11, 6'd20, 6'd21);
    wait_valid(1, lat);
    chk("rec_lat", 64'(lat), 64'd5);
    chk("rec_nreq", 64'(req_log.size() - base), 64'd2);
    chk("rec_tag", 64'(bus.opc_tag), 64'd7);
    chk_ops("rec_op0", 0, 1'b0, 20);
    chk_ops("rec_op1", 1, 1'b0, 21);
    issue_now(7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
